// File: rtl/cgra_output_write_master.sv
// CGRA result write master: buffers per-node output words, arbitrates round-robin
// and emits single-beat strided AXI-Lite writes on a 64-bit bus, pulsing done_o at the end.
module cgra_output_write_master #(
    parameter int OUTPUT_NODES_NUM  = 4,
    parameter int OUTPUT_FIFO_DEPTH = 4,
    parameter int MAX_OUTSTANDING   = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                execute_i,
    input  logic [32*OUTPUT_NODES_NUM-1:0]      data_output_i,
    input  logic [OUTPUT_NODES_NUM-1:0]         data_output_valid_i,
    output logic [OUTPUT_NODES_NUM-1:0]         data_output_ready_o,
    input  logic [OUTPUT_NODES_NUM-1:0][31:0]   data_output_addr_i,
    input  logic [OUTPUT_NODES_NUM-1:0][15:0]   data_output_size_i,
    input  logic [OUTPUT_NODES_NUM-1:0][15:0]   data_output_stride_i,
    output logic                                done_o,
    output logic                                error_o,
    output logic [31:0]                         axi_aw_addr_o,
    output logic [2:0]                          axi_aw_prot_o,
    output logic                                axi_aw_valid_o,
    input  logic                                axi_aw_ready_i,
    output logic [63:0]                         axi_w_data_o,
    output logic [7:0]                          axi_w_strb_o,
    output logic                                axi_w_valid_o,
    input  logic                                axi_w_ready_i,
    input  logic [1:0]                          axi_b_resp_i,
    input  logic                                axi_b_valid_i,
    output logic                                axi_b_ready_o,
    output logic [31:0]                         axi_ar_addr_o,
    output logic [2:0]                          axi_ar_prot_o,
    output logic                                axi_ar_valid_o,
    output logic                                axi_r_ready_o
);
    localparam int NW = (OUTPUT_NODES_NUM > 1) ? $clog2(OUTPUT_NODES_NUM) : 1;
    localparam int PW = (OUTPUT_FIFO_DEPTH > 1) ? $clog2(OUTPUT_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(OUTPUT_FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [NW-1:0] rr_ptr_q, rr_ptr_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          error_q, error_d;
    logic          aw_valid_q, aw_valid_d;
    logic [31:0]   aw_addr_q, aw_addr_d;
    logic          w_valid_q, w_valid_d;
    logic [63:0]   w_data_q, w_data_d;
    logic [7:0]    w_strb_q, w_strb_d;

    logic start, run, aw_free, w_free, grant_any, b_dec, all_done;
    logic [NW-1:0] grant_idx;
    int            arb_idx;
    logic [OUTPUT_NODES_NUM-1:0] grant_vec, fifo_full, fifo_empty, req, node_done;
    logic [OUTPUT_NODES_NUM-1:0][31:0] fifo_head, node_addr;
    logic [31:0] sel_addr, sel_word;

    assign start    = (state_q == ST_IDLE) && execute_i;
    assign run      = (state_q == ST_RUN);
    assign aw_free  = !aw_valid_q || axi_aw_ready_i;
    assign w_free   = !w_valid_q || axi_w_ready_i;
    assign b_dec    = axi_b_valid_i && (outst_q != '0);
    assign all_done = &node_done;

    for (genvar gi = 0; gi < OUTPUT_NODES_NUM; gi++) begin : g_node
        logic [31:0]   mem_q [OUTPUT_FIFO_DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [31:0]   base_q, base_d, offs_q, offs_d, pend_q, pend_d, size32;
        logic [15:0]   size_q, size_d, stride_q, stride_d;
        logic          push, pop;

        assign size32                  = {16'd0, size_q};
        assign push                    = data_output_valid_i[gi] && data_output_ready_o[gi];
        assign pop                     = grant_vec[gi];
        assign fifo_full[gi]           = (cnt_q == CW'(OUTPUT_FIFO_DEPTH));
        assign fifo_empty[gi]          = (cnt_q == '0);
        // pend tracks accepted words, offs tracks granted ones; both scaled by stride
        assign data_output_ready_o[gi] = run && !fifo_full[gi] && (pend_q < size32);
        assign req[gi]                 = !fifo_empty[gi] && (offs_q < size32);
        assign node_done[gi]           = (offs_q >= size32);
        assign node_addr[gi]           = base_q + offs_q;
        assign fifo_head[gi]           = mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (push) wr_ptr_d = (wr_ptr_q == PW'(OUTPUT_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == PW'(OUTPUT_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            cnt_d    = CW'(cnt_q + CW'(push) - CW'(pop));
            base_d   = start ? data_output_addr_i[gi]   : base_q;
            size_d   = start ? data_output_size_i[gi]   : size_q;
            stride_d = start ? data_output_stride_i[gi] : stride_q;
            offs_d   = offs_q;
            pend_d   = pend_q;
            if (start) begin
                offs_d = '0;
                pend_d = '0;
            end else begin
                if (pop)  offs_d = offs_q + {16'd0, stride_q};
                if (push) pend_d = pend_q + {16'd0, stride_q};
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                base_q   <= '0;
                size_q   <= '0;
                stride_q <= '0;
                offs_q   <= '0;
                pend_q   <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                base_q   <= base_d;
                size_q   <= size_d;
                stride_q <= stride_d;
                offs_q   <= offs_d;
                pend_q   <= pend_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_ptr_q] <= data_output_i[32*gi +: 32];
        end
    end

    // Round-robin: rr_ptr holds the first node to consider on the next grant
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        arb_idx   = 0;
        if (run && aw_free && w_free && (outst_q < OW'(MAX_OUTSTANDING))) begin
            for (int k = 0; k < OUTPUT_NODES_NUM; k++) begin
                arb_idx = (int'(rr_ptr_q) + k) % OUTPUT_NODES_NUM;
                if (!grant_any && req[arb_idx]) begin
                    grant_any          = 1'b1;
                    grant_idx          = NW'(arb_idx);
                    grant_vec[arb_idx] = 1'b1;
                end
            end
        end
        rr_ptr_d = grant_any ? NW'((int'(grant_idx) + 1) % OUTPUT_NODES_NUM) : rr_ptr_q;
        sel_addr = node_addr[grant_idx];
        sel_word = fifo_head[grant_idx];
    end

    always_comb begin
        aw_valid_d = aw_valid_q && !axi_aw_ready_i;
        aw_addr_d  = aw_addr_q;
        w_valid_d  = w_valid_q && !axi_w_ready_i;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        if (grant_any) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = sel_addr & 32'hFFFF_FFF8;
            w_valid_d  = 1'b1;
            w_data_d   = {sel_word, sel_word};
            w_strb_d   = sel_addr[2] ? 8'hF0 : 8'h0F;
        end
        outst_d = OW'(outst_q + OW'(grant_any) - OW'(b_dec));
        error_d = error_q;
        if (start) error_d = 1'b0;
        if (axi_b_valid_i && (axi_b_resp_i != 2'b00)) error_d = 1'b1;
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (execute_i) state_d = ST_RUN;
            ST_RUN:  if (all_done && !aw_valid_q && !w_valid_q && (outst_q == '0)) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            outst_q    <= '0;
            error_q    <= 1'b0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            outst_q    <= outst_d;
            error_q    <= error_d;
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
        end
    end

    assign done_o         = (state_q == ST_DONE);
    assign error_o        = error_q;
    assign axi_aw_addr_o  = aw_addr_q;
    assign axi_aw_prot_o  = 3'b000;
    assign axi_aw_valid_o = aw_valid_q;
    assign axi_w_data_o   = w_data_q;
    assign axi_w_strb_o   = w_strb_q;
    assign axi_w_valid_o  = w_valid_q;
    assign axi_b_ready_o  = 1'b1;
    assign axi_ar_addr_o  = '0;
    assign axi_ar_prot_o  = 3'b000;
    assign axi_ar_valid_o = 1'b0;
    assign axi_r_ready_o  = 1'b0;
endmodule
